sipo_frame_controller: RTL and testbench
========================================

SIPO_FRAME_CONTROLLER -- requirements
Module: sipo_frame_controller

Interface
REQ-001 Parameter WIDTH, default 4: number of data bits per frame; legal range 2..16.
REQ-002 Parameter PARITY_EN, default 1: 1 means an even-parity bit follows the data bits; 0 means no parity bit.
REQ-003 CLK  input  1  sole clock; all state updates on the rising edge.
REQ-004 Reset  input  1  synchronous, active-low reset; sampled on the rising edge of CLK.
REQ-005 D  input  1  serial data bit; sampled only when D_En=1.
REQ-006 D_En  input  1  bit strobe; one serial bit is offered per cycle in which D_En=1.
REQ-007 Out_Ready  input  1  downstream accepts Q in a cycle where Out_Valid=1.
REQ-008 Q  output  WIDTH  assembled parallel frame; first received bit is in the MSB.
REQ-009 Out_Valid  output  1  Q and Parity_Err hold a complete frame.
REQ-010 Parity_Err  output  1  the held frame failed even parity; always 0 when PARITY_EN=0.
REQ-011 Busy  output  1  high in the SHIFT and PARITY states.
REQ-012 Overrun  output  1  sticky flag: a strobe arrived while a frame was held.

Function
REQ-013 The FSM SHALL have the states IDLE, SHIFT, PARITY and HOLD, and all outputs SHALL be registered.
REQ-014 IDLE: a cycle with D_En=1 and D=1 is a start bit. On the next edge the FSM goes to SHIFT, the bit counter clears to 0 and the internal shift register clears to 0. A cycle with D_En=1 and D=0 is ignored.
REQ-015 SHIFT: each D_En=1 cycle SHALL shift the register left (shreg <= {shreg[WIDTH-2:0], D}) and increment the counter. A D_En=0 cycle holds all state; gaps of any length are legal.
REQ-016 When the WIDTH-th data bit is accepted, the FSM SHALL go to PARITY if PARITY_EN=1, otherwise to HOLD.
REQ-017 PARITY: the next D_En=1 cycle samples the parity bit and the FSM goes to HOLD. Parity_Err SHALL be set to the XOR of all WIDTH data bits and the parity bit (nonzero means error).
REQ-018 On entry to HOLD, Q SHALL load the shift register and Out_Valid SHALL rise. Out_Valid is therefore high in the cycle after the last accepted strobe (data bit or parity bit): latency 1 cycle.
REQ-019 In HOLD, Q, Parity_Err and Out_Valid SHALL stay stable until a cycle with Out_Ready=1. After that edge the FSM is in IDLE and Out_Valid=0. Q and Parity_Err keep their last values until the next HOLD entry.
REQ-020 Any D_En=1 cycle in HOLD, including the handshake cycle itself, SHALL be discarded and SHALL set Overrun. Overrun is cleared only by reset.
REQ-021 Out_Ready SHALL be ignored in every state except HOLD.
REQ-022 Busy SHALL be 1 exactly when the state is SHIFT or PARITY.
REQ-023 The bit counter SHALL be ceil(log2(WIDTH+1)) bits wide and SHALL never wrap; it clears on every start bit.

Reset
REQ-024 With Reset=0 at a rising edge, the block SHALL enter IDLE and set to 0: Q, the shift register, the counter, Out_Valid, Parity_Err, Busy and Overrun.
REQ-025 Reset SHALL take priority over every other input in every state, including mid-frame and during HOLD. A partial frame is discarded with no Out_Valid pulse.
REQ-026 The first cycle after Reset returns to 1 SHALL be able to accept a start bit.

Verification (WIDTH=4, PARITY_EN=1 unless noted)
REQ-027 Back-to-back strobes with D = 1,1,0,1,1,1 (start, data 1011, parity 1) and Out_Ready=1 -> Q=4'b1011, Parity_Err=0, Out_Valid high for exactly 1 cycle, 1 cycle after the parity strobe.
REQ-028 Same frame with parity bit 0 -> Q=4'b1011, Parity_Err=1.
REQ-029 Frame 1,0,1,1,0,1 with 3-cycle D_En=0 gaps between bits and Out_Ready=0 for 5 cycles -> Q=4'b0110 held stable with Out_Valid=1 throughout; a strobe during the hold sets Overrun=1 and leaves Q unchanged.
REQ-030 Reset pulsed low after 2 data bits -> all outputs 0, state IDLE, no Out_Valid; a following complete frame 1,0,0,0,1,1 gives Q=4'b0001, Parity_Err=0.
REQ-031 PARITY_EN=0, strobes 1,1,1,1,1 -> Q=4'b1111 and Out_Valid 1 cycle after the 4th data bit; Parity_Err=0.
REQ-032 In IDLE, strobes with D=0 for 10 cycles -> Busy=0, Out_Valid=0, state remains IDLE.

Source files
------------

// File: rtl/sipo_frame_controller_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sipo_frame_controller_if : serial-in / parallel-out frame bus bundle
// Revision 1.0
// ----------------------------------------------------------------------------
interface sipo_frame_controller_if #(
  parameter int WIDTH = 4
) ();
  logic             i_d;
  logic             i_d_en;
  logic             i_out_ready;
  logic [WIDTH-1:0] o_q;
  logic             o_out_valid;
  logic             o_parity_err;
  logic             o_busy;
  logic             o_overrun;

  modport slave (
    input  i_d, i_d_en, i_out_ready,
    output o_q, o_out_valid, o_parity_err, o_busy, o_overrun
  );

  modport master (
    output i_d, i_d_en, i_out_ready,
    input  o_q, o_out_valid, o_parity_err, o_busy, o_overrun
  );
endinterface
`default_nettype wire

// File: rtl/sipo_frame_controller.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sipo_frame_controller : start-bit framed serial receiver with optional even
// parity, held output with valid/ready handshake. Revision 1.0
// ----------------------------------------------------------------------------
module sipo_frame_controller #(
  parameter int WIDTH     = 4,
  parameter int PARITY_EN = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  sipo_frame_controller_if.slave  bus
);
  localparam int             CW     = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  C_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0]  C_ONE  = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_PARITY = 2'd2,
    S_HOLD   = 2'd3
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_shreg, w_shreg_nxt;
  logic [CW-1:0]    r_cnt,   w_cnt_nxt;
  logic [WIDTH-1:0] r_q,     w_q_nxt;
  logic             r_perr,  w_perr_nxt;
  logic             r_ovr,   w_ovr_nxt;
  logic             r_valid;
  logic             r_busy;
  logic [WIDTH-1:0] w_shifted;

  assign w_shifted = {r_shreg[WIDTH-2:0], bus.i_d};

  always_comb begin
    w_state_nxt = r_state;
    w_shreg_nxt = r_shreg;
    w_cnt_nxt   = r_cnt;
    w_q_nxt     = r_q;
    w_perr_nxt  = r_perr;
    w_ovr_nxt   = r_ovr;
    case (r_state)
      S_IDLE: begin
        if (bus.i_d_en && bus.i_d) begin
          w_state_nxt = S_SHIFT;
          w_shreg_nxt = '0;
          w_cnt_nxt   = '0;
        end
      end
      S_SHIFT: begin
        if (bus.i_d_en) begin
          w_shreg_nxt = w_shifted;
          w_cnt_nxt   = r_cnt + C_ONE;
          if (r_cnt == C_LAST) begin
            if (PARITY_EN != 0) begin
              w_state_nxt = S_PARITY;
            end else begin
              w_state_nxt = S_HOLD;
              w_q_nxt     = w_shifted;
              w_perr_nxt  = 1'b0;
            end
          end
        end
      end
      S_PARITY: begin
        if (bus.i_d_en) begin
          w_state_nxt = S_HOLD;
          w_q_nxt     = r_shreg;
          w_perr_nxt  = ^{r_shreg, bus.i_d};
        end
      end
      S_HOLD: begin
        // Strobes here, including the handshake cycle, are dropped and flagged.
        if (bus.i_d_en) begin
          w_ovr_nxt = 1'b1;
        end
        if (bus.i_out_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_shreg <= '0;
      r_cnt   <= '0;
      r_q     <= '0;
      r_perr  <= 1'b0;
      r_ovr   <= 1'b0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_shreg <= w_shreg_nxt;
      r_cnt   <= w_cnt_nxt;
      r_q     <= w_q_nxt;
      r_perr  <= w_perr_nxt;
      r_ovr   <= w_ovr_nxt;
      r_valid <= (w_state_nxt == S_HOLD);
      r_busy  <= (w_state_nxt == S_SHIFT) || (w_state_nxt == S_PARITY);
    end
  end

  assign bus.o_q          = r_q;
  assign bus.o_out_valid  = r_valid;
  assign bus.o_parity_err = r_perr;
  assign bus.o_busy       = r_busy;
  assign bus.o_overrun    = r_ovr;
endmodule
`default_nettype wire

// File: tb/tb_sipo_frame_controller.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_sipo_frame_controller : directed bench for parity and no-parity variants
// Revision 1.0
// ----------------------------------------------------------------------------
module tb_sipo_frame_controller;
  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  sipo_frame_controller_if #(.WIDTH(4)) if_p ();
  sipo_frame_controller_if #(.WIDTH(4)) if_np ();

  sipo_frame_controller #(.WIDTH(4), .PARITY_EN(1)) u_dut_p (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_p.slave)
  );

  sipo_frame_controller #(.WIDTH(4), .PARITY_EN(0)) u_dut_np (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_np.slave)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Both DUTs see the same inputs; returns on the falling edge after the
  // rising edge that consumed them.
  task automatic tick(input logic en, input logic d, input logic rdy);
    if_p.i_d_en = en;  if_p.i_d = d;  if_p.i_out_ready = rdy;
    if_np.i_d_en = en; if_np.i_d = d; if_np.i_out_ready = rdy;
    @(negedge clk);
  endtask

  task automatic send_bits(input logic [5:0] bits, input int n, input int gap, input logic rdy);
    logic [5:0] v;
    v = bits;
    for (int i = 0; i < n; i++) begin
      if (i != 0) repeat (gap) tick(1'b0, 1'b0, rdy);
      tick(1'b1, v[5-i], rdy);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
  endtask

  initial begin
    clk   = 1'b0;
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    check_val("rst_q",     32'(if_p.o_q), 32'h0);
    check_val("rst_valid", 32'(if_p.o_out_valid), 32'h0);
    check_val("rst_perr",  32'(if_p.o_parity_err), 32'h0);
    check_val("rst_busy",  32'(if_p.o_busy), 32'h0);
    check_val("rst_ovr",   32'(if_p.o_overrun), 32'h0);
    check_val("rst_np_q",  32'(if_np.o_q), 32'h0);
    rst_n = 1'b1;

    // Good-parity frame, back to back, ready high throughout
    send_bits(6'b110111, 5, 0, 1'b1);
    check_val("f1_busy_pre",  32'(if_p.o_busy), 32'h1);
    check_val("f1_valid_pre", 32'(if_p.o_out_valid), 32'h0);
    tick(1'b1, 1'b1, 1'b1);
    check_val("f1_valid", 32'(if_p.o_out_valid), 32'h1);
    check_val("f1_q",     32'(if_p.o_q), 32'hB);
    check_val("f1_perr",  32'(if_p.o_parity_err), 32'h0);
    check_val("f1_busy",  32'(if_p.o_busy), 32'h0);
    tick(1'b0, 1'b0, 1'b1);
    check_val("f1_valid_off", 32'(if_p.o_out_valid), 32'h0);
    check_val("f1_q_keep",    32'(if_p.o_q), 32'hB);
    check_val("f1_ovr",       32'(if_p.o_overrun), 32'h0);

    // Bad parity; strobe in the handshake cycle is discarded and flags overrun
    send_bits(6'b110110, 6, 0, 1'b1);
    check_val("f2_q",    32'(if_p.o_q), 32'hB);
    check_val("f2_perr", 32'(if_p.o_parity_err), 32'h1);
    check_val("f2_valid", 32'(if_p.o_out_valid), 32'h1);
    tick(1'b1, 1'b1, 1'b1);
    check_val("f2_valid_off", 32'(if_p.o_out_valid), 32'h0);
    check_val("f2_ovr",       32'(if_p.o_overrun), 32'h1);
    check_val("f2_no_start",  32'(if_p.o_busy), 32'h0);
    tick(1'b0, 1'b0, 1'b0);
    check_val("f2_idle", 32'(if_p.o_busy), 32'h0);
    check_val("f2_ovr_sticky", 32'(if_p.o_overrun), 32'h1);

    do_reset();
    check_val("r1_ovr", 32'(if_p.o_overrun), 32'h0);

    // Gapped frame, held for five cycles with one overrun strobe
    send_bits(6'b101101, 5, 3, 1'b0);
    check_val("f3_busy", 32'(if_p.o_busy), 32'h1);
    repeat (2) tick(1'b0, 1'b0, 1'b0);
    check_val("f3_gap_busy",  32'(if_p.o_busy), 32'h1);
    check_val("f3_gap_valid", 32'(if_p.o_out_valid), 32'h0);
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 1'b0);
    check_val("f3_valid", 32'(if_p.o_out_valid), 32'h1);
    check_val("f3_q",     32'(if_p.o_q), 32'h6);
    check_val("f3_perr",  32'(if_p.o_parity_err), 32'h1);
    for (int i = 0; i < 5; i++) begin
      tick((i == 2), 1'b1, 1'b0);
      check_val("f3_hold_valid", 32'(if_p.o_out_valid), 32'h1);
      check_val("f3_hold_q",     32'(if_p.o_q), 32'h6);
      check_val("f3_hold_ovr",   32'(if_p.o_overrun), (i >= 2) ? 32'h1 : 32'h0);
    end
    tick(1'b0, 1'b0, 1'b1);
    check_val("f3_valid_off", 32'(if_p.o_out_valid), 32'h0);
    check_val("f3_q_keep",    32'(if_p.o_q), 32'h6);

    // Reset mid-frame, with a strobe present, then an immediate new frame
    do_reset();
    send_bits(6'b110000, 3, 0, 1'b0);
    check_val("f4_busy_mid", 32'(if_p.o_busy), 32'h1);
    rst_n = 1'b0;
    tick(1'b1, 1'b1, 1'b1);
    rst_n = 1'b1;
    check_val("f4_rst_busy",  32'(if_p.o_busy), 32'h0);
    check_val("f4_rst_valid", 32'(if_p.o_out_valid), 32'h0);
    check_val("f4_rst_q",     32'(if_p.o_q), 32'h0);
    check_val("f4_rst_perr",  32'(if_p.o_parity_err), 32'h0);
    send_bits(6'b100011, 6, 0, 1'b0);
    check_val("f4_valid", 32'(if_p.o_out_valid), 32'h1);
    check_val("f4_q",     32'(if_p.o_q), 32'h1);
    check_val("f4_perr",  32'(if_p.o_parity_err), 32'h0);
    tick(1'b0, 1'b0, 1'b1);
    check_val("f4_valid_off", 32'(if_p.o_out_valid), 32'h0);

    // Zero strobes in IDLE never start a frame
    for (int i = 0; i < 10; i++) begin
      tick(1'b1, 1'b0, 1'b0);
      check_val("idle_busy",  32'(if_p.o_busy), 32'h0);
      check_val("idle_valid", 32'(if_p.o_out_valid), 32'h0);
    end

    // No-parity variant: valid one cycle after the fourth data bit
    do_reset();
    send_bits(6'b111110, 4, 0, 1'b0);
    check_val("np_valid_pre", 32'(if_np.o_out_valid), 32'h0);
    check_val("np_busy_pre",  32'(if_np.o_busy), 32'h1);
    tick(1'b1, 1'b1, 1'b0);
    check_val("np_valid", 32'(if_np.o_out_valid), 32'h1);
    check_val("np_q",     32'(if_np.o_q), 32'hF);
    check_val("np_perr",  32'(if_np.o_parity_err), 32'h0);
    check_val("np_busy",  32'(if_np.o_busy), 32'h0);
    check_val("p_in_parity", 32'(if_p.o_busy), 32'h1);
    tick(1'b0, 1'b0, 1'b1);
    check_val("np_valid_off", 32'(if_np.o_out_valid), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire
